ptw_mem_responder: RTL and testbench

Memory-side responder for the page-table walker's PTE read port (`addr`/`ren`/`rdata`/`mmu_stall`). It converts walker read requests into request/grant/rvalid transactions on the shared memory bus, holds `ptw_stall` high until the requested doubleword is available, and keeps a one-entry PTE buffer so that a held address is answered without stalling. It sits between the MMU and the memory arbiter, with a timeout path that returns an invalid PTE so the walker can never hang.

---
 rtl/ptw_mem_responder.sv | 164 ++++++++++++++++
 tb/tb_ptw_mem_responder.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/ptw_mem_responder.sv
// ptw_mem_responder
//   Services the page-table walker's PTE read port from the shared memory bus.
//   A one-entry buffer answers a held address with no stall; a miss becomes a
//   req/gnt/rvalid transaction. A timer abandons a transaction that never
//   completes and returns an all-zero (invalid) PTE so the walker cannot hang.
//
// Ports
//   clk, rst           clock; asynchronous active-low reset
//   ptw_addr/ptw_ren   walker request (addr[2:0] ignored)
//   ptw_rdata          buffered PTE, valid when ptw_ren && !ptw_stall
//   ptw_stall          combinational: requested doubleword not yet buffered
//   flush              invalidate the buffer (satp write / sfence)
//   mem_req/mem_addr   registered bus request, held until mem_gnt
//   mem_gnt            request accepted
//   mem_rvalid/rdata   read response
//   timeout_err        one-cycle pulse when a request is abandoned
module ptw_mem_responder #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] ptw_addr,
  input  logic        ptw_ren,
  output logic [63:0] ptw_rdata,
  output logic        ptw_stall,
  input  logic        flush,
  output logic        mem_req,
  output logic [63:0] mem_addr,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [63:0] mem_rdata,
  output logic        timeout_err
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  localparam logic [15:0] TMAX = 16'(TIMEOUT - 1);

  state_t      state, state_d;
  logic        mem_req_d, terr_d;
  logic [60:0] maddr, maddr_d;
  logic [60:0] req_addr, req_addr_d;
  logic [15:0] timer, timer_d;
  logic        buf_valid, buf_valid_d;
  logic [60:0] buf_addr, buf_addr_d;
  logic [63:0] buf_data, buf_data_d;
  logic        orphan, orphan_d;
  logic        stale, stale_d;
  logic        fill;
  logic [63:0] fill_data;
  logic        hit;
  logic        unused_lsb;

  assign unused_lsb = ^ptw_addr[2:0];

  assign hit       = ptw_ren && buf_valid && (buf_addr == ptw_addr[63:3]);
  assign ptw_stall = ptw_ren && !hit;
  assign ptw_rdata = buf_data;
  assign mem_addr  = {maddr, 3'b000};

  always_comb begin
    state_d     = state;
    mem_req_d   = mem_req;
    maddr_d     = maddr;
    req_addr_d  = req_addr;
    timer_d     = timer;
    buf_valid_d = buf_valid;
    buf_addr_d  = buf_addr;
    buf_data_d  = buf_data;
    orphan_d    = orphan;
    stale_d     = stale;
    terr_d      = 1'b0;
    fill        = 1'b0;
    fill_data   = '0;

    case (state)
      IDLE: begin
        // The response to a transaction abandoned in WAIT may still arrive;
        // swallow it before letting a new request onto the bus.
        if (orphan) begin
          if (mem_rvalid) orphan_d = 1'b0;
        end else if (ptw_ren && !hit) begin
          req_addr_d = ptw_addr[63:3];
          maddr_d    = ptw_addr[63:3];
          stale_d    = 1'b0;
          mem_req_d  = 1'b1;
          timer_d    = '0;
          state_d    = REQ;
        end
      end
      REQ: begin
        if (mem_gnt) begin
          mem_req_d = 1'b0;
          timer_d   = '0;
          state_d   = WAIT;
        end else if (timer == TMAX) begin
          fill      = 1'b1;
          terr_d    = 1'b1;
          mem_req_d = 1'b0;
          timer_d   = '0;
          state_d   = IDLE;
        end else begin
          timer_d = timer + 16'd1;
        end
      end
      WAIT: begin
        if (mem_rvalid) begin
          fill      = 1'b1;
          fill_data = mem_rdata;
          state_d   = IDLE;
        end else if (timer == TMAX) begin
          fill     = 1'b1;
          terr_d   = 1'b1;
          orphan_d = 1'b1;
          timer_d  = '0;
          state_d  = IDLE;
        end else begin
          timer_d = timer + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    // A flush while a fetch is in flight means its data predates the flush.
    if (flush && state != IDLE) stale_d = 1'b1;

    // Timeouts fill with zero so the walker sees V=0 and faults cleanly.
    if (fill) begin
      buf_addr_d  = req_addr;
      buf_data_d  = fill_data;
      buf_valid_d = !stale && !flush;
    end
    if (flush) buf_valid_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      mem_req     <= 1'b0;
      maddr       <= '0;
      req_addr    <= '0;
      timer       <= '0;
      buf_valid   <= 1'b0;
      buf_addr    <= '0;
      buf_data    <= '0;
      orphan      <= 1'b0;
      stale       <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_d;
      mem_req     <= mem_req_d;
      maddr       <= maddr_d;
      req_addr    <= req_addr_d;
      timer       <= timer_d;
      buf_valid   <= buf_valid_d;
      buf_addr    <= buf_addr_d;
      buf_data    <= buf_data_d;
      orphan      <= orphan_d;
      stale       <= stale_d;
      timeout_err <= terr_d;
    end
  end

endmodule

// File: tb/tb_ptw_mem_responder.sv
// Directed bench for ptw_mem_responder (TIMEOUT=8). Inputs change 1ns after
// the rising edge; outputs are sampled on the falling edge.
module tb_ptw_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] ptw_addr;
  logic        ptw_ren;
  logic [63:0] ptw_rdata;
  logic        ptw_stall;
  logic        flush;
  logic        mem_req;
  logic [63:0] mem_addr;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [63:0] mem_rdata;
  logic        timeout_err;

  int checks = 0;
  int failures = 0;
  int n_txn = 0;

  always #5 clk = ~clk;

  ptw_mem_responder #(.TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .ptw_addr(ptw_addr), .ptw_ren(ptw_ren),
    .ptw_rdata(ptw_rdata), .ptw_stall(ptw_stall),
    .flush(flush),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .timeout_err(timeout_err)
  );

  // bus handshakes seen by the bench
  always @(posedge clk) if (rst && mem_req && mem_gnt) n_txn <= n_txn + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] a3 [3];
    logic [63:0] d3 [3];
    int t0;
    a3[0] = 64'h8000_1008; a3[1] = 64'h8000_2010; a3[2] = 64'h8000_3018;
    d3[0] = 64'h2000_1001; d3[1] = 64'h2000_2001; d3[2] = 64'h2000_30CF;

    rst = 1'b0; ptw_addr = '0; ptw_ren = 1'b0; flush = 1'b0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;

    // ---- reset state
    #12;
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_stall_ren0", ptw_stall, 0);
    chk("rst_rdata", ptw_rdata, 0);
    chk("rst_terr", timeout_err, 0);
    ptw_ren = 1'b1; #1;
    chk("rst_stall_ren1", ptw_stall, 1);
    ptw_ren = 1'b0;

    // ---- single miss, minimum latency
    nxt(); rst = 1'b1; ptw_ren = 1'b1; ptw_addr = 64'h8000_1000;
    smp(); chk("t1_c0_stall", ptw_stall, 1); chk("t1_c0_req", mem_req, 0);
    nxt(); mem_gnt = 1'b1;
    smp(); chk("t1_c1_req", mem_req, 1); chk("t1_c1_addr", mem_addr, 64'h8000_1000);
    nxt(); mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 64'h2000_0C01;
    smp(); chk("t1_c2_req", mem_req, 0); chk("t1_c2_stall", ptw_stall, 1);
    nxt(); mem_rvalid = 1'b0; mem_rdata = '0;
    smp(); chk("t1_c3_stall", ptw_stall, 0); chk("t1_c3_rdata", ptw_rdata, 64'h2000_0C01);
    nxt();
    smp(); chk("t1_hold_noreq", mem_req, 0); chk("t1_hold_stall", ptw_stall, 0);

    // ---- three-level walk, gnt delayed 4 cycles per level
    t0 = n_txn;
    for (int l = 0; l < 3; l++) begin
      nxt(); ptw_addr = a3[l];
      smp(); chk("t2_c0_stall", ptw_stall, 1);
      for (int c = 0; c < 4; c++) begin
        nxt();
        smp(); chk("t2_req_wait", mem_req, 1); chk("t2_addr_stable", mem_addr, a3[l]);
      end
      nxt(); mem_gnt = 1'b1;
      smp(); chk("t2_req_gnt", mem_req, 1);
      nxt(); mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = d3[l];
      nxt(); mem_rvalid = 1'b0; mem_rdata = '0;
      smp(); chk("t2_stall", ptw_stall, 0); chk("t2_rdata", ptw_rdata, d3[l]);
    end
    chk("t2_txn_count", 64'(n_txn - t0), 3);

    // ---- timeout in REQ: gnt never comes
    nxt(); ptw_addr = 64'h8000_4000;
    smp(); chk("t3_c0_stall", ptw_stall, 1);
    for (int c = 1; c <= 8; c++) begin
      nxt();
      smp(); chk("t3_req_held", mem_req, 1); chk("t3_no_terr", timeout_err, 0);
    end
    nxt();
    smp(); chk("t3_terr", timeout_err, 1); chk("t3_stall", ptw_stall, 0);
    chk("t3_rdata0", ptw_rdata, 0); chk("t3_req_off", mem_req, 0);
    nxt();
    smp(); chk("t3_terr_pulse", timeout_err, 0);

    // ---- timeout in WAIT, late rvalid discarded
    ptw_addr = 64'h8000_5000;
    smp(); chk("t4_c0_stall", ptw_stall, 1);
    nxt(); mem_gnt = 1'b1;                       // c1
    nxt(); mem_gnt = 1'b0;                       // c2: WAIT timer=0
    for (int c = 2; c <= 9; c++) begin
      smp(); chk("t4_wait_noterr", timeout_err, 0);
      nxt();
    end
    smp(); chk("t4_terr", timeout_err, 1); chk("t4_stall", ptw_stall, 0);  // c10
    nxt(); ptw_addr = 64'h8000_6000;             // c11
    smp(); chk("t4_orphan_noreq", mem_req, 0); chk("t4_new_stall", ptw_stall, 1);
    nxt();                                       // c12
    smp(); chk("t4_orphan_noreq2", mem_req, 0);
    nxt(); mem_rvalid = 1'b1; mem_rdata = 64'hDEAD_BEEF_0000_0001;  // c13
    smp(); chk("t4_discard_noreq", mem_req, 0);
    nxt(); mem_rvalid = 1'b0; mem_rdata = '0;    // c14
    smp(); chk("t4_late_stall", ptw_stall, 1); chk("t4_late_rdata", ptw_rdata, 0);
    chk("t4_c14_req", mem_req, 0);
    nxt(); mem_gnt = 1'b1;                       // c15
    smp(); chk("t4_new_req", mem_req, 1); chk("t4_new_addr", mem_addr, 64'h8000_6000);
    nxt(); mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 64'h3001;
    nxt(); mem_rvalid = 1'b0; mem_rdata = '0;
    smp(); chk("t4_new_stall0", ptw_stall, 0); chk("t4_new_rdata", ptw_rdata, 64'h3001);

    // ---- flush in the rvalid cycle forces a refetch
    nxt(); ptw_addr = 64'h8000_7000;             // c0
    nxt(); mem_gnt = 1'b1;                       // c1
    nxt(); mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 64'h4001; flush = 1'b1;  // c2
    nxt(); mem_rvalid = 1'b0; mem_rdata = '0; flush = 1'b0;  // c3
    smp(); chk("t5_stall", ptw_stall, 1); chk("t5_c3_req", mem_req, 0);
    nxt(); mem_gnt = 1'b1;                       // c4
    smp(); chk("t5_refetch_req", mem_req, 1); chk("t5_refetch_addr", mem_addr, 64'h8000_7000);
    nxt(); mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 64'h4005;
    nxt(); mem_rvalid = 1'b0; mem_rdata = '0;
    smp(); chk("t5_stall0", ptw_stall, 0); chk("t5_rdata", ptw_rdata, 64'h4005);

    // ---- reset during WAIT
    nxt(); ptw_addr = 64'h8000_8000;             // c0
    nxt(); mem_gnt = 1'b1;                       // c1
    nxt(); mem_gnt = 1'b0; rst = 1'b0;           // c2 (was WAIT)
    smp(); chk("t6_rst_req", mem_req, 0); chk("t6_rst_stall", ptw_stall, 1);
    chk("t6_rst_rdata", ptw_rdata, 0);
    nxt(); rst = 1'b1; ptw_ren = 1'b0; mem_rvalid = 1'b1; mem_rdata = 64'h5555;  // c3
    smp(); chk("t6_ren0_stall", ptw_stall, 0); chk("t6_c3_req", mem_req, 0);
    nxt(); mem_rvalid = 1'b0; mem_rdata = '0; ptw_ren = 1'b1;  // c4
    smp(); chk("t6_stray_stall", ptw_stall, 1); chk("t6_stray_rdata", ptw_rdata, 0);
    nxt(); mem_gnt = 1'b1;                       // c5
    smp(); chk("t6_req", mem_req, 1); chk("t6_addr", mem_addr, 64'h8000_8000);
    nxt(); mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 64'h6001;
    nxt(); mem_rvalid = 1'b0; mem_rdata = '0;
    smp(); chk("t6_stall0", ptw_stall, 0); chk("t6_rdata", ptw_rdata, 64'h6001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
